// File: rtl/npu_result_packer.sv
// Deskews per-lane systolic accumulators into rows and requantizes each lane to int8.
// Packs one row per 32-bit word and streams the words out through a FWFT FIFO with credit-based admission.
module npu_result_packer #(
  parameter int N          = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int LANE_DEPTH = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic [4:0]                cfg_shift,
  input  logic                      cfg_relu,
  input  logic [N*ACC_WIDTH-1:0]    core_y_out,
  input  logic [N-1:0]              core_valid_out,
  output logic [N*OUT_WIDTH-1:0]    out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      almost_full,
  output logic                      overflow,
  output logic [31:0]               row_count
);

  localparam int VW  = ACC_WIDTH + 1;
  localparam int WW  = N * OUT_WIDTH;
  localparam int LPW = (LANE_DEPTH > 1) ? $clog2(LANE_DEPTH) : 1;
  localparam int LCW = $clog2(LANE_DEPTH + 1);
  localparam int FPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OCW = FCW + 1;
  localparam logic signed [VW-1:0] SAT_MAX = VW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [VW-1:0] SAT_MIN = VW'(-(2 ** (OUT_WIDTH - 1)));

  logic [N-1:0]   lane_nonempty;
  logic [N-1:0]   lane_high;
  logic [N-1:0]   lane_drop;
  logic [WW-1:0]  s2_word;
  logic           pop;
  logic [OCW-1:0] occ;
  logic           fifo_push;
  logic           fifo_pop;

  logic           s1_valid_q;
  logic           s1_relu_q;
  logic [WW-1:0]  fifo_mem [FIFO_DEPTH];
  logic [FPW-1:0] fifo_wr_q;
  logic [FPW-1:0] fifo_rd_q;
  logic [FCW-1:0] fifo_cnt_q;
  logic           overflow_q;
  logic [31:0]    row_count_q;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [ACC_WIDTH-1:0]   mem_q [LANE_DEPTH];
      logic [LPW-1:0]         wr_q;
      logic [LPW-1:0]         rd_q;
      logic [LCW-1:0]         cnt_q;
      logic                   full;
      logic                   push;
      logic signed [VW-1:0]   ext;
      logic signed [VW-1:0]   rnd;
      logic signed [VW-1:0]   v_d;
      logic signed [VW-1:0]   v_q;
      logic signed [VW-1:0]   r;

      // A pop in the same cycle frees the slot, so a push at full is still accepted.
      assign full               = (cnt_q == LCW'(LANE_DEPTH));
      assign push               = core_valid_out[gi] && (!full || pop);
      assign lane_drop[gi]      = core_valid_out[gi] && full && !pop;
      assign lane_nonempty[gi]  = (cnt_q != '0);
      assign lane_high[gi]      = (cnt_q >= LCW'(LANE_DEPTH - 1));

      always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= core_y_out[gi*ACC_WIDTH +: ACC_WIDTH];
      end

      always_ff @(posedge clk) begin
        if (rst || clear) begin
          wr_q  <= '0;
          rd_q  <= '0;
          cnt_q <= '0;
        end else begin
          if (push) wr_q <= (wr_q == LPW'(LANE_DEPTH - 1)) ? '0 : wr_q + LPW'(1);
          if (pop)  rd_q <= (rd_q == LPW'(LANE_DEPTH - 1)) ? '0 : rd_q + LPW'(1);
          cnt_q <= cnt_q + LCW'(push) - LCW'(pop);
        end
      end

      // 33-bit round-half-up then arithmetic shift; the extra bit keeps the add from wrapping.
      assign ext = VW'($signed(mem_q[rd_q]));
      assign rnd = (cfg_shift == 5'd0) ? '0 : (VW'(1) << (cfg_shift - 5'd1));
      assign v_d = (ext + rnd) >>> cfg_shift;

      always_ff @(posedge clk) begin
        if (pop) v_q <= v_d;
      end

      assign r = (s1_relu_q && v_q[VW-1]) ? '0 : v_q;
      assign s2_word[gi*OUT_WIDTH +: OUT_WIDTH] =
          (r > SAT_MAX) ? SAT_MAX[OUT_WIDTH-1:0] :
          (r < SAT_MIN) ? SAT_MIN[OUT_WIDTH-1:0] : r[OUT_WIDTH-1:0];
    end
  endgenerate

  // The S2 stage writes straight into the output FIFO, so only S1 holds a row in flight.
  assign occ         = OCW'(fifo_cnt_q) + OCW'(s1_valid_q);
  assign pop         = (&lane_nonempty) && (occ < OCW'(FIFO_DEPTH));
  assign almost_full = (occ >= OCW'(FIFO_DEPTH - 2)) || (|lane_high);
  assign fifo_push   = s1_valid_q;
  assign fifo_pop    = out_valid && out_ready;
  assign out_valid   = (fifo_cnt_q != '0);
  assign out_data    = out_valid ? fifo_mem[fifo_rd_q] : '0;
  assign overflow    = overflow_q;
  assign row_count   = row_count_q;

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[fifo_wr_q] <= s2_word;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s1_valid_q  <= 1'b0;
      s1_relu_q   <= 1'b0;
      fifo_wr_q   <= '0;
      fifo_rd_q   <= '0;
      fifo_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      row_count_q <= '0;
    end else begin
      s1_valid_q <= pop;
      if (pop) s1_relu_q <= cfg_relu;
      fifo_wr_q   <= fifo_wr_q + FPW'(fifo_push);
      fifo_rd_q   <= fifo_rd_q + FPW'(fifo_pop);
      fifo_cnt_q  <= fifo_cnt_q + FCW'(fifo_push) - FCW'(fifo_pop);
      overflow_q  <= overflow_q | (|lane_drop);
      if (fifo_pop) row_count_q <= row_count_q + 32'd1;
    end
  end

endmodule
